// File: rtl/scratchpad_port_arbiter.sv
// Round-robin burst arbiter sharing one single-port scratchpad between
// weight fetch, input-feature fetch and result writeback.
module scratchpad_port_arbiter #(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 64,
    parameter int BURST_MAX = 16,
    parameter int LEN_W     = $clog2(BURST_MAX + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              w_req,
    input  logic [ADDR_W-1:0] w_addr,
    input  logic [LEN_W-1:0]  w_len,
    output logic              w_gnt,
    output logic              w_rvalid,
    output logic              w_done,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic [LEN_W-1:0]  if_len,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic              if_done,
    input  logic              o_req,
    input  logic [ADDR_W-1:0] o_addr,
    input  logic [LEN_W-1:0]  o_len,
    output logic              o_gnt,
    input  logic [DATA_W-1:0] o_wdata,
    output logic              o_pop,
    output logic              o_done,
    output logic [DATA_W-1:0] rd_data,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_e;
    typedef enum logic [1:0] {OWN_W, OWN_IF, OWN_O} own_e;

    state_e            state_q;
    own_e              owner_q;
    own_e              rr_q;
    logic [ADDR_W-1:0] base_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  beat_q;
    logic              rvalid_q;

    own_e              win;
    logic              win_vld;
    logic [ADDR_W-1:0] sel_addr;
    logic [LEN_W-1:0]  sel_len;
    logic              grant;
    logic              zero_len;
    logic              issue;
    logic              last_beat;
    logic              wr;
    logic              drain;

    // First requester after the last owner, in W -> IF -> O order.
    always_comb begin
        win_vld = w_req | if_req | o_req;
        win     = OWN_W;
        unique case (rr_q)
            OWN_W:   win = if_req ? OWN_IF : (o_req ? OWN_O : OWN_W);
            OWN_IF:  win = o_req ? OWN_O : (w_req ? OWN_W : OWN_IF);
            default: win = w_req ? OWN_W : (if_req ? OWN_IF : OWN_O);
        endcase
    end

    always_comb begin
        sel_addr = w_addr;
        sel_len  = w_len;
        unique case (win)
            OWN_IF: begin
                sel_addr = if_addr;
                sel_len  = if_len;
            end
            OWN_O: begin
                sel_addr = o_addr;
                sel_len  = o_len;
            end
            default: ;
        endcase
    end

    assign grant     = rst & (state_q == IDLE) & win_vld;
    assign zero_len  = (sel_len == '0);
    assign issue     = (state_q == ISSUE);
    assign drain     = (state_q == DRAIN);
    assign wr        = issue & (owner_q == OWN_O);
    assign last_beat = issue & (beat_q == len_q - LEN_W'(1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            owner_q  <= OWN_W;
            rr_q     <= OWN_O;
            base_q   <= '0;
            len_q    <= '0;
            beat_q   <= '0;
            rvalid_q <= 1'b0;
        end else begin
            rvalid_q <= issue & (owner_q != OWN_O);
            unique case (state_q)
                IDLE: begin
                    if (grant) begin
                        owner_q <= win;
                        rr_q    <= win;
                        base_q  <= sel_addr;
                        len_q   <= sel_len;
                        beat_q  <= '0;
                        if (!zero_len) state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    beat_q <= beat_q + LEN_W'(1);
                    if (last_beat)
                        state_q <= (owner_q == OWN_O) ? IDLE : DRAIN;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign w_gnt  = grant & (win == OWN_W);
    assign if_gnt = grant & (win == OWN_IF);
    assign o_gnt  = grant & (win == OWN_O);

    assign mem_en    = issue;
    assign mem_we    = wr;
    assign mem_addr  = issue ? base_q + ADDR_W'(beat_q) : '0;
    assign mem_wdata = wr ? o_wdata : '0;
    assign o_pop     = wr;

    assign w_rvalid  = rvalid_q & (owner_q == OWN_W);
    assign if_rvalid = rvalid_q & (owner_q == OWN_IF);
    assign rd_data   = rvalid_q ? mem_rdata : '0;

    // Zero-length bursts complete in their grant cycle.
    assign w_done  = (grant & zero_len & (win == OWN_W))
                   | (drain & (owner_q == OWN_W));
    assign if_done = (grant & zero_len & (win == OWN_IF))
                   | (drain & (owner_q == OWN_IF));
    assign o_done  = (grant & zero_len & (win == OWN_O))
                   | (last_beat & wr);

    assign busy = (state_q != IDLE);

endmodule

// File: doc/scratchpad_port_arbiter.md
Name: scratchpad_port_arbiter

Overview:
Shares the single-port on-chip scratchpad between three burst requesters: weight fetch (W), input-feature fetch (IF) and result writeback (O). It sits between the weight/IF loaders driven by the controller and the SRAM macro. Grants whole bursts round-robin, generates the per-beat SRAM addresses, returns read data with per-requester valid strobes, and pulses a per-requester done flag.

Parameters:
ADDR_W, 16, scratchpad word-address width
DATA_W, 64, scratchpad word width
BURST_MAX, 16, maximum burst length in words
LEN_W, $clog2(BURST_MAX+1), width of burst-length fields (derived)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
w_req  in  1  weight-read burst request
w_addr  in  ADDR_W  weight burst base address
w_len  in  LEN_W  weight burst length (0..BURST_MAX)
w_gnt  out  1  weight burst accepted (1-cycle pulse)
w_rvalid  out  1  rd_data holds a weight word
w_done  out  1  weight burst complete (1-cycle pulse)
if_req, if_addr, if_len, if_gnt, if_rvalid, if_done  same as W, for input-feature reads
o_req  in  1  writeback burst request
o_addr  in  ADDR_W  writeback base address
o_len  in  LEN_W  writeback burst length
o_gnt  out  1  writeback accepted (pulse)
o_wdata  in  DATA_W  writeback word, must be valid while o_pop=1
o_pop  out  1  o_wdata consumed this cycle
o_done  out  1  writeback complete (pulse)
rd_data  out  DATA_W  shared read-return data
mem_en  out  1  SRAM access enable
mem_we  out  1  SRAM write enable
mem_addr  out  ADDR_W  SRAM address
mem_wdata  out  DATA_W  SRAM write data
mem_rdata  in  DATA_W  SRAM read data, valid one cycle after a read mem_en
busy  out  1  burst in progress (state != IDLE)

Behaviour:
- Reset (rst=0, async): state IDLE, rr pointer = O (so W has first priority), beat counter 0; all outputs 0.
- States: IDLE, ISSUE, DRAIN.
- IDLE: if any req: pick first requesting in order after rr pointer (W->IF->O->W); assert that gnt combinationally this cycle; latch owner, base addr, len; update rr pointer to owner. len!=0 -> ISSUE; len==0 -> assert owner done in the same cycle as gnt, no memory access, stay IDLE.
- ISSUE: one beat per cycle, beats 0..len-1: mem_en=1, mem_addr=(base+beat) mod 2^ADDR_W (wraps, no error). O owner: mem_we=1, mem_wdata=o_wdata, o_pop=1 same cycle. After beat len-1: O -> assert o_done with last beat, go IDLE; W/IF -> DRAIN.
- Read return: X_rvalid=1 and rd_data=mem_rdata exactly one cycle after each read beat; rd_data=0 when no rvalid. DRAIN holds the last return; X_done asserted with last rvalid; next state IDLE.
- Timing (grant cycle G): beats G+1..G+len; read data G+2..G+len+1, done G+len+1; write done G+len. Earliest next grant: done+1.
- Requests sampled only in IDLE; req/addr/len ignored while busy. Req may drop before gnt (withdraw). Req held after done is a new request and competes normally.
- Only one of w/if/o gnt, rvalid, done asserted per cycle; mem_we=0 on all read beats.
- rst asserted mid-burst: immediate return to reset values; outstanding burst abandoned, no done pulse; requesters must re-request.
- len > BURST_MAX: undefined; checked by assertion in verification only.

Test Plan:
- Single W read, w_addr=0x0010, w_len=4, mem_rdata=addr-tagged -> w_gnt at G, mem_addr 0x10..0x13 at G+1..G+4, w_rvalid G+2..G+5, w_done at G+5, busy G+1..G+5.
- w_req, if_req, o_req all held from reset, len=2 each -> grants in order W, IF, O, W; no overlapping mem_en; exactly one done per burst.
- Write burst o_addr=0x0100, o_len=3 -> o_pop and mem_we high for 3 cycles, mem_wdata tracks o_wdata, o_done on 3rd beat, no rvalid.
- Wrap: if_addr=0xFFFE, if_len=4 -> mem_addr 0xFFFE, 0xFFFF, 0x0000, 0x0001.
- w_len=0 -> w_gnt and w_done same cycle, mem_en never asserted, IF granted next cycle if pending.
- rst pulsed low at beat 2 of an 8-beat IF read -> all outputs 0 immediately, no if_done; after release W wins arbitration.
